// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among N_REQ
//            byte requesters. Captures the granted byte, launches it with a
//            one-cycle strobe, waits for frame completion (with a timeout
//            guard) and then holds off for a programmable inter-frame gap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Master_Clk        in   1         system clock, rising edge
//   Master_Rst_n      in   1         asynchronous active-low reset
//   req_valid         in   N_REQ     per-requester byte pending
//   req_data          in   8*N_REQ   requester i byte at [8i+7:8i]
//   req_ready         out  N_REQ     one-hot, one-cycle accept pulse
//   tx_datavalid      out  1         one-cycle launch strobe to transmitter
//   Byte_to_transmit  out  8         byte to transmitter, held between launches
//   tx_active         in   1         transmitter busy (launch qualifier only)
//   tx_complete       in   1         transmitter frame-done pulse
//   grant_id          out  ID_W      index of last/current granted requester
//   busy              out  1         arbiter not idle
//   timeout_err       out  1         one-cycle pulse on launch timeout
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int CLK_PER_BIT  = 104,
  parameter int TIMEOUT_CLKS = 12 * CLK_PER_BIT,
  parameter int GAP_CLKS     = CLK_PER_BIT
) (
  input  logic               Master_Clk,
  input  logic               Master_Rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_datavalid,
  output logic [7:0]         Byte_to_transmit,
  input  logic               tx_active,
  input  logic               tx_complete,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  localparam logic [ID_W:0] c_LAST_IDX = (ID_W+1)'(N_REQ - 1);
  localparam logic [15:0]   c_TO_LAST  = 16'(TIMEOUT_CLKS - 1);
  // Only reachable when GAP_CLKS > 0, so the wrap for GAP_CLKS = 0 is harmless.
  localparam logic [15:0]   c_GAP_LAST = 16'(GAP_CLKS - 1);

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]      r_last_grant;
  logic [N_REQ-1:0]     r_req_ready;
  logic                 r_tx_datavalid;
  logic [7:0]           r_byte;
  logic [ID_W-1:0]      r_grant_id;
  logic                 r_timeout_err;

  logic [ID_W-1:0]      w_sel;
  logic                 w_any;
  logic [ID_W:0]        w_idx;
  logic [N_REQ-1:0]     w_rv_shift;
  logic [8*N_REQ-1:0]   w_data_shift;
  logic                 w_launch;
  logic                 w_timeout;

  // Round-robin pick: walk indices starting just after the last grant,
  // wrapping at N_REQ, and take the first one with a pending request.
  always_comb begin
    w_sel      = '0;
    w_any      = 1'b0;
    w_idx      = {1'b0, r_last_grant};
    w_rv_shift = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx      = (w_idx == c_LAST_IDX) ? '0 : w_idx + 1'b1;
      w_rv_shift = req_valid >> w_idx;
      if (!w_any && w_rv_shift[0]) begin
        w_sel = w_idx[ID_W-1:0];
        w_any = 1'b1;
      end
    end
  end

  assign w_data_shift = req_data >> {w_sel, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_launch    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (w_any && !tx_active) begin
          w_launch    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A completion in the final cycle wins over the timeout.
        if (tx_complete || (r_cnt == c_TO_LAST)) begin
          w_timeout   = !tx_complete;
          w_cnt_nxt   = '0;
          w_state_nxt = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Master_Clk or negedge Master_Rst_n) begin
    if (!Master_Rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_last_grant   <= ID_W'(N_REQ - 1);
      r_req_ready    <= '0;
      r_tx_datavalid <= 1'b0;
      r_byte         <= '0;
      r_grant_id     <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_tx_datavalid <= w_launch;
      r_timeout_err  <= w_timeout;
      r_req_ready    <= w_launch ? (N_REQ'(1) << w_sel) : '0;
      if (w_launch) begin
        r_byte       <= w_data_shift[7:0];
        r_grant_id   <= w_sel;
        r_last_grant <= w_sel;
      end
    end
  end

  assign req_ready        = r_req_ready;
  assign tx_datavalid     = r_tx_datavalid;
  assign Byte_to_transmit = r_byte;
  assign grant_id         = r_grant_id;
  assign timeout_err      = r_timeout_err;
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. A hand-derived vector
//            table, directed timeout/coincidence/reset sequences, and a random
//            run against a timestamp-based reference model with a simple
//            behavioural transmitter stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int T  = 50;
  localparam int G  = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   rv = '0;
  logic [31:0]  rd = 32'h43322110;
  logic         txa = 1'b0;
  logic         txc = 1'b0;
  logic [3:0]   req_ready;
  logic         tx_datavalid;
  logic [7:0]   byte_out;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  uart_tx_arbiter #(
    .N_REQ(N), .ID_W(2), .CLK_PER_BIT(4), .TIMEOUT_CLKS(T), .GAP_CLKS(G)
  ) dut (
    .Master_Clk(clk), .Master_Rst_n(rst_n),
    .req_valid(rv), .req_data(rd), .req_ready(req_ready),
    .tx_datavalid(tx_datavalid), .Byte_to_transmit(byte_out),
    .tx_active(txa), .tx_complete(txc),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks whether a frame is outstanding and the first
  // edge at which a new launch is permitted.
  int          cyc;
  bit          m_wait;
  int          m_launch;
  int          m_free;
  int          m_last;
  logic [3:0]  e_ready;
  logic        e_dv, e_to, e_busy;
  logic [7:0]  e_byte;
  logic [1:0]  e_grant;

  task automatic model_reset();
    cyc = 0; m_wait = 0; m_launch = 0; m_free = 0; m_last = N - 1;
    e_ready = '0; e_dv = 0; e_to = 0; e_busy = 0; e_byte = '0; e_grant = '0;
  endtask

  task automatic model_edge();
    int sel;
    e_ready = '0; e_dv = 0; e_to = 0;
    if (!m_wait && cyc >= m_free) begin
      if (rv != 0 && !txa) begin
        sel = -1;
        for (int d = 1; d <= N; d++)
          if (sel < 0 && rv[(m_last + d) % N]) sel = (m_last + d) % N;
        e_ready[sel] = 1'b1;
        e_dv    = 1'b1;
        e_grant = 2'(sel);
        e_byte  = rd[8*sel +: 8];
        m_last  = sel;
        m_wait  = 1;
        m_launch = cyc;
      end
    end else if (m_wait) begin
      if (txc) begin
        m_wait = 0; m_free = cyc + G + 1;
      end else if (cyc == m_launch + T) begin
        e_to = 1'b1; m_wait = 0; m_free = cyc + G + 1;
      end
    end
    e_busy = m_wait || (cyc + 1 < m_free);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("req_ready",    req_ready,    e_ready);
    chk("tx_datavalid", tx_datavalid, e_dv);
    chk("byte",         byte_out,     e_byte);
    chk("grant_id",     grant_id,     e_grant);
    chk("busy",         busy,         e_busy);
    chk("timeout_err",  timeout_err,  e_to);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rv = '0; txa = 0; txc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] rv; logic txa; logic txc;
    logic [3:0] ready; logic dv; logic [1:0] grant; logic [7:0] bt; logic busy; logic to;
  } vec_t;

  vec_t tbl[19];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, s_rem;
    //            rv     txa  txc  ready  dv  grant byte   busy to
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[2]  = '{4'hE, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[3]  = '{4'hE, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[4]  = '{4'hE, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[5]  = '{4'hE, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[6]  = '{4'hE, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[7]  = '{4'hE, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};
    tbl[8]  = '{4'hE, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h10, 1'b0, 1'b0};
    tbl[9]  = '{4'hE, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 8'h10, 1'b0, 1'b0};
    tbl[10] = '{4'hE, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[11] = '{4'hC, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[12] = '{4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[13] = '{4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[14] = '{4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[15] = '{4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h21, 1'b1, 1'b0};
    tbl[16] = '{4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h21, 1'b0, 1'b0};
    tbl[17] = '{4'hC, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2, 8'h32, 1'b1, 1'b0};
    tbl[18] = '{4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 8'h32, 1'b1, 1'b0};

    // Reset state, checked while reset is held.
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_dv", tx_datavalid, 0);
    chk("reset_ready", req_ready, 0);
    do_reset();

    // Table phase.
    for (int i = 0; i < 19; i++) begin
      rv = tbl[i].rv; txa = tbl[i].txa; txc = tbl[i].txc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_dv", i), tx_datavalid, tbl[i].dv);
      chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].grant);
      chk($sformatf("tbl%0d_byte", i), byte_out, tbl[i].bt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_to", i), timeout_err, tbl[i].to);
    end

    // Timeout with a pending request behind it.
    do_reset();
    rv = 4'b0001; txa = 0; txc = 0;
    tick();
    rv = 4'b0010;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (timeout_err) begin lat = i; break; end
    end
    chk("timeout_latency", lat, T);
    lat2 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!busy) begin lat2 = i; break; end
    end
    chk("gap_len", lat2, G);
    tick();
    chk("post_gap_launch", {tx_datavalid, grant_id}, {1'b1, 2'd1});

    // tx_complete landing on the timeout cycle.
    rv = 4'b0000;
    for (int i = 1; i < T; i++) tick();
    txc = 1;
    tick();
    txc = 0;
    chk("coincident_no_timeout", timeout_err, 0);
    chk("coincident_busy", busy, 1);
    repeat (G + 2) tick();

    // Reset asserted mid-frame.
    rv = 4'b0100;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 0);
    chk("midrst_dv", tx_datavalid, 0);
    chk("midrst_byte", byte_out, 0);
    chk("midrst_grant", grant_id, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_to", timeout_err, 0);
    rv = 4'b1001; txa = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    txa = 0;
    tick();
    chk("rst_first_grant", {tx_datavalid, grant_id}, {1'b1, 2'd0});

    // Randomized run with a behavioural transmitter stub.
    do_reset();
    s_rem = 0;
    for (int c = 0; c < 3000; c++) begin
      txa = (s_rem > 0);
      txc = (s_rem == 1) || (s_rem == 0 && $urandom_range(0, 24) == 0);
      tick();
      if (s_rem > 0) s_rem--;
      if (tx_datavalid) s_rem = $urandom_range(2, 55);
      for (int i = 0; i < N; i++) begin
        if (rv[i] && req_ready[i]) rv[i] = 1'b0;
        else if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          rd[8*i +: 8] = 8'($urandom);
        end else if (rv[i] && $urandom_range(0, 59) == 0) rv[i] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART_Transmitter among N_REQ byte requesters using round-robin arbitration.
- Captures the granted requester's byte and launches it with a single-cycle tx_datavalid pulse.
- Waits for tx_complete, with a timeout guard, then enforces a programmable inter-frame gap.
- Sits between client logic and the UART_Transmitter; its transmitter-side ports connect directly to that module's ports of the same name.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must equal ceil(log2(N_REQ))
CLK_PER_BIT, 104, clocks per UART bit (Clock Frequency/Baud Rate); documentation and default-derivation only
TIMEOUT_CLKS, 1248, max clocks from launch to tx_complete (12 bit times); 1..65535
GAP_CLKS, 104, idle clocks enforced after each frame ends (done or timeout); 0..65535

Ports:
Master_Clk  in  1  system clock, rising edge
Master_Rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a byte pending; held until req_ready[i] seen
req_data  in  8*N_REQ  requester i byte at bits [8i+7:8i]; stable while req_valid[i]=1
req_ready  out  N_REQ  one-hot, one-cycle accept pulse; byte captured
tx_datavalid  out  1  one-cycle launch strobe to transmitter
Byte_to_transmit  out  8  byte to transmitter; held stable between launches
tx_active  in  1  transmitter busy
tx_complete  in  1  transmitter frame-done pulse
grant_id  out  ID_W  index of last/current granted requester
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on launch timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE; tx_datavalid=0; req_ready=0; Byte_to_transmit=0; grant_id=0; busy=0; timeout_err=0; counter=0; last_grant=N_REQ-1, so requester 0 has first priority.
- Reset mid-frame: outputs drop immediately. The transmitter is not reset by this block. After release, the next launch waits for tx_active=0.
- States: IDLE, WAIT_DONE, GAP.
- IDLE:
  - At edge k, launch if (|req_valid) && !tx_active.
  - sel = first i with req_valid[i]=1, scanning (last_grant+1) mod N_REQ upward with wrap.
  - At edge k: Byte_to_transmit<=req_data[sel], grant_id<=sel, last_grant<=sel, req_ready[sel]<=1, tx_datavalid<=1, counter<=0, state<=WAIT_DONE.
  - At edge k+1: tx_datavalid and req_ready return to 0. Each is exactly one cycle wide.
  - Otherwise remain in IDLE.
- WAIT_DONE:
  - counter increments each cycle.
  - tx_complete=1 -> state<=GAP, counter<=0. This takes priority over timeout in the same cycle.
  - Else if counter==TIMEOUT_CLKS-1 -> timeout_err<=1 for one cycle, state<=GAP, counter<=0.
  - req_valid and req_data are not sampled in this state.
- GAP:
  - counter increments each cycle.
  - When counter==GAP_CLKS-1 -> IDLE.
  - If GAP_CLKS=0, go from WAIT_DONE straight to IDLE.
  - Launch-to-launch minimum is therefore frame time + GAP_CLKS + 1.
- tx_complete outside WAIT_DONE is ignored. tx_active is used only as the IDLE launch qualifier.
- A requester dropping req_valid before it is granted is legal; that request is simply not served.
- Counter width is 16 bits; no wrap is possible within the legal parameter range.
- busy is combinational from state: (state!=IDLE).

Test Plan:
1. Loopback through UART_Transmitter and UART_Receiver at CLK_PER_BIT=104; requester 1 sends 0xAB -> req_ready=4'b0010 for one cycle; tx_datavalid one cycle; grant_id=1; Rx_Byte=0xAB at tx_complete; timeout_err never asserts.
2. All four requesters valid at the same edge with 0x10/0x21/0x32/0x43 -> grants 0,1,2,3 in order; receiver sees 0x10,0x21,0x32,0x43; each tx_datavalid is ≥GAP_CLKS+1 cycles after the prior tx_complete.
3. Requesters 0 and 2 continuously valid for 6 frames -> grant sequence 0,2,0,2,0,2; requesters 1 and 3 never get req_ready.
4. tx_complete tied 0, TIMEOUT_CLKS=50, GAP_CLKS=5 -> timeout_err pulses exactly 50 cycles after the launch edge; busy falls 5 cycles later; a pending request then launches on the next cycle.
5. Master_Rst_n pulsed low mid-WAIT_DONE -> all outputs 0 immediately; after release with tx_active=1 and req_valid[3]=1 -> no launch until tx_active=0, then grant_id=0 if req_valid[0]=1, else grant_id=3.
6. Spurious tx_complete pulse in IDLE, and tx_complete coincident with the timeout cycle -> no state effect in IDLE; coincident case goes to GAP with timeout_err=0.
